// File: rtl/jt89_bus_ctrl_if.sv
// jt89_bus_ctrl_if: CPU write bus and PSG register outputs of the bus controller
interface jt89_bus_ctrl_if;
  logic       clk_en;
  logic       wr_n;
  logic [7:0] din;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       noise_rst;
  modport master (
    output clk_en, wr_n, din,
    input  ready, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, noise_rst
  );
  modport slave (
    input  clk_en, wr_n, din,
    output ready, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, noise_rst
  );
endinterface

// File: rtl/jt89_bus_ctrl.sv
// jt89_bus_ctrl: SN76489-style CPU write decoder with latch/data bytes and a 32-tick busy timer
module jt89_bus_ctrl (
  input logic           clk,
  input logic           rst,
  jt89_bus_ctrl_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q;
  logic        ready_q, wr_q, typ_q, noise_q;
  logic [1:0]  chan_q;
  logic [4:0]  cnt_q;
  logic [9:0]  tone_q [3];
  logic [3:0]  vol_q [4];
  logic [2:0]  ctrl3_q;
  logic        acc_d, typ_d;
  logic [1:0]  chan_d;
  // accept only on a fresh falling strobe while idle; data bytes reuse the last latch
  always_comb begin
    acc_d  = !bus.wr_n && wr_q && ready_q;
    chan_d = bus.din[7] ? bus.din[6:5] : chan_q;
    typ_d  = bus.din[7] ? bus.din[4] : typ_q;
  end
  // register file, latch and busy-timer state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      wr_q    <= 1'b1;
      cnt_q   <= '0;
      chan_q  <= '0;
      typ_q   <= 1'b0;
      noise_q <= 1'b0;
      ctrl3_q <= '0;
      for (int i = 0; i < 3; i++) tone_q[i] <= '0;
      for (int i = 0; i < 4; i++) vol_q[i] <= 4'hF;
    end else begin
      wr_q    <= bus.wr_n;
      noise_q <= 1'b0;
      if (acc_d) begin
        state_q <= BUSY;
        ready_q <= 1'b0;
        cnt_q   <= 5'd31;
        if (bus.din[7]) begin
          chan_q <= bus.din[6:5];
          typ_q  <= bus.din[4];
        end
        if (typ_d) vol_q[chan_d] <= bus.din[3:0];
        else if (chan_d == 2'd3) begin
          ctrl3_q <= bus.din[2:0];
          noise_q <= 1'b1;
        end else
          for (int i = 0; i < 3; i++)
            if (chan_d == 2'(i))
              tone_q[i] <= bus.din[7] ? {tone_q[i][9:4], bus.din[3:0]} : {bus.din[5:0], tone_q[i][3:0]};
      end else if (state_q == BUSY && bus.clk_en) begin
        if (cnt_q == 5'd0) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end else cnt_q <= cnt_q - 5'd1;
      end
    end
  end
  assign bus.ready     = ready_q;
  assign bus.tone0     = tone_q[0];
  assign bus.tone1     = tone_q[1];
  assign bus.tone2     = tone_q[2];
  assign bus.vol0      = vol_q[0];
  assign bus.vol1      = vol_q[1];
  assign bus.vol2      = vol_q[2];
  assign bus.vol3      = vol_q[3];
  assign bus.ctrl3     = ctrl3_q;
  assign bus.noise_rst = noise_q;
endmodule

// File: tb/tb_jt89_bus_ctrl.sv
// tb_jt89_bus_ctrl: directed register-write, busy-timer, held-strobe and reset checks
module tb_jt89_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int npulse = 0;
  int ens = 0;
  jt89_bus_ctrl_if bus ();
  jt89_bus_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // count cycles with noise_rst high, seen at each rising edge
  always @(posedge clk) if (bus.noise_rst) npulse++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic wait_ready;
    for (int i = 0; i < 300 && !bus.ready; i++) tick();
    chk("wait_ready", 16'(bus.ready), 16'd1);
  endtask
  task automatic wr(input logic [7:0] b);
    bus.din  = b;
    bus.wr_n = 1'b0;
    tick();
    bus.wr_n = 1'b1;
  endtask
  initial begin
    bus.clk_en = 1'b1;
    bus.wr_n   = 1'b1;
    bus.din    = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 16'(bus.ready), 16'd1);
    chk("rst_tone0", 16'(bus.tone0), 16'h000);
    chk("rst_vols", {bus.vol0, bus.vol1, bus.vol2, bus.vol3}, 16'hFFFF);
    chk("rst_ctrl3", 16'(bus.ctrl3), 16'd0);
    chk("rst_noise", 16'(bus.noise_rst), 16'd0);
    npulse = 0;
    wr(8'h8E);
    chk("tone_latch_busy", 16'(bus.ready), 16'd0);
    chk("tone_latch", 16'(bus.tone0), 16'h00E);
    wait_ready();
    wr(8'h0F);
    chk("tone_data", 16'(bus.tone0), 16'h0FE);
    wait_ready();
    chk("tone_no_noise", 16'(npulse), 16'd0);
    wr(8'hD5);
    chk("vol_latch", 16'(bus.vol2), 16'h5);
    wait_ready();
    wr(8'h0A);
    chk("vol_data", 16'(bus.vol2), 16'hA);
    chk("vol_tone2", 16'(bus.tone2), 16'h000);
    wait_ready();
    npulse = 0;
    wr(8'hE6);
    chk("noise_latch", 16'(bus.ctrl3), 16'h6);
    chk("noise_pulse_hi", 16'(bus.noise_rst), 16'd1);
    tick();
    chk("noise_pulse_lo", 16'(bus.noise_rst), 16'd0);
    chk("noise_cnt1", 16'(npulse), 16'd1);
    wait_ready();
    wr(8'h03);
    chk("noise_data", 16'(bus.ctrl3), 16'h3);
    wait_ready();
    chk("noise_cnt2", 16'(npulse), 16'd2);
    wr(8'h81);
    ens = 0;
    for (int k = 0; k < 400; k++) begin
      bus.clk_en = (k % 4 == 3);
      if (k == 20) begin
        bus.din  = 8'h9F;
        bus.wr_n = 1'b0;
      end
      if (k == 22) bus.wr_n = 1'b1;
      if (bus.clk_en) ens++;
      tick();
      if (bus.ready) break;
    end
    bus.clk_en = 1'b1;
    chk("busy_pulses", 16'(ens), 16'd32);
    chk("busy_ready", 16'(bus.ready), 16'd1);
    chk("busy_ignored", 16'(bus.tone0), 16'h0F1);
    chk("busy_vol0", 16'(bus.vol0), 16'hF);
    wr(8'h82);
    repeat (31) tick();
    chk("expiry_still_busy", 16'(bus.ready), 16'd0);
    bus.din  = 8'h8F;
    bus.wr_n = 1'b0;
    tick();
    chk("expiry_ready", 16'(bus.ready), 16'd1);
    repeat (3) tick();
    chk("expiry_ignored", 16'(bus.tone0), 16'h0F2);
    chk("expiry_idle", 16'(bus.ready), 16'd1);
    bus.wr_n = 1'b1;
    tick();
    bus.din  = 8'h97;
    bus.wr_n = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == 40) bus.din = 8'h9C;
      tick();
    end
    chk("held_vol0", 16'(bus.vol0), 16'h7);
    chk("held_ready", 16'(bus.ready), 16'd1);
    bus.wr_n = 1'b1;
    tick();
    bus.clk_en = 1'b0;
    wr(8'hB2);
    repeat (50) tick();
    chk("stuck_busy", 16'(bus.ready), 16'd0);
    chk("stuck_vol1", 16'(bus.vol1), 16'h2);
    bus.clk_en = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 16'(bus.ready), 16'd1);
    chk("mid_rst_vols", {bus.vol0, bus.vol1, bus.vol2, bus.vol3}, 16'hFFFF);
    chk("mid_rst_tone0", 16'(bus.tone0), 16'h000);
    chk("mid_rst_tone12", {bus.tone1[7:0], bus.tone2[7:0]}, 16'h0000);
    chk("mid_rst_ctrl3", 16'(bus.ctrl3), 16'd0);
    wr(8'h3F);
    chk("post_rst_data", 16'(bus.tone0), 16'h3F0);
    wait_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jt89_bus_ctrl.md
JT89_BUS_CTRL -- requirements
Module: jt89_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (system clock, all state on rising edge); rst input 1 (synchronous, active-high).
REQ-002 The block SHALL have input clk_en, 1 bit: PSG clock enable; the busy timer advances only when it is high.
REQ-003 The block SHALL have input wr_n, 1 bit: active-low CPU write strobe, synchronous to clk.
REQ-004 The block SHALL have input din, 8 bits: CPU write byte.
REQ-005 The block SHALL have output ready, 1 bit: high means a write will be accepted.
REQ-006 The block SHALL have outputs tone0, tone1, tone2, each 10 bits: period registers for the three tone channels.
REQ-007 The block SHALL have outputs vol0, vol1, vol2, vol3, each 4 bits: attenuation per channel; 4'hF is silent.
REQ-008 The block SHALL have output ctrl3, 3 bits: noise control; bit2 selects white/periodic, bits1:0 select the rate.
REQ-009 The block SHALL have output noise_rst, 1 bit: one-clk pulse on any write to the noise control register.
REQ-010 All outputs SHALL be registered.

Function
REQ-011 A write SHALL be accepted at the rising clk edge where wr_n is 0, the registered previous wr_n sample is 1, and ready is 1; din is sampled at that edge.
REQ-012 A falling wr_n edge while ready is 0 SHALL be ignored, with no register, latch or timer change; holding wr_n low SHALL NOT produce a second write.
REQ-013 Latch byte (din[7]=1): the block SHALL store chan=din[6:5] and typ=din[4] in the latch register.
REQ-014 Latch byte, typ=1: the block SHALL set vol[chan] to din[3:0].
REQ-015 Latch byte, typ=0, chan 0-2: the block SHALL set tone[chan][3:0] to din[3:0]; tone[chan][9:4] is unchanged.
REQ-016 Latch byte, typ=0, chan 3: the block SHALL set ctrl3 to din[2:0] and pulse noise_rst.
REQ-017 Data byte (din[7]=0): the latch SHALL be unchanged, and the byte SHALL act on the last latched chan/typ.
REQ-018 Data byte, typ=0, chan 0-2: the block SHALL set tone[chan][9:4] to din[5:0].
REQ-019 Data byte, typ=0, chan 3: the block SHALL set ctrl3 to din[2:0] and pulse noise_rst.
REQ-020 Data byte, typ=1: the block SHALL set vol[chan] to din[3:0].
REQ-021 Latency: register outputs SHALL change at the accepting edge and be visible in the next cycle; noise_rst SHALL be high for exactly the one cycle following the accepting edge.
REQ-022 Busy timer: on an accepted write, ready SHALL go 0 at the same edge and a 5-bit counter SHALL load 31.
REQ-023 While busy, each clk_en=1 cycle SHALL decrement the counter; the clk_en cycle that finds the counter at 0 SHALL set ready to 1, giving exactly 32 clk_en pulses of busy time.
REQ-024 Busy timer with clk_en stuck at 0: ready SHALL stay 0 indefinitely.
REQ-025 States: IDLE (ready=1) and BUSY (ready=0); transitions are only IDLE->BUSY on an accepted write and BUSY->IDLE on counter expiry.
REQ-026 Simultaneous events: a wr_n falling edge in the same cycle as counter expiry SHALL be ignored, because ready was 0 at that edge.

Reset
REQ-027 When rst=1 the block SHALL, at the next clk edge, set: tone0-2 to 0; vol0-3 to 4'hF; ctrl3 to 0; noise_rst to 0; ready to 1; busy counter to 0; latch to chan=0, typ=0; registered wr_n sample to 1.
REQ-028 rst SHALL override any write or busy activity in the same cycle; reset asserted mid-BUSY SHALL return the block to IDLE.
REQ-029 rst SHALL take effect regardless of clk_en.

Verification
REQ-030 Tone write: latch 0x8E, then data 0x0F, with clk_en always 1 and each write after ready returns -> tone0=10'h0FE, noise_rst never high.
REQ-031 Volume write: latch 0xD5 (chan2, vol=5), then data 0x0A -> vol2=5 after the first write, vol2=4'hA after the second, tone2 unchanged.
REQ-032 Noise write: latch 0xE6 -> ctrl3=3'b110, with exactly one noise_rst pulse. Data 0x03 -> ctrl3=3'b011, with a second single pulse.
REQ-033 Busy timing: write with clk_en high every 4th clk -> ready low for exactly 32 clk_en pulses. A second wr_n falling edge during busy -> no register change.
REQ-034 Held strobe: wr_n held low for 100 clk -> exactly one write is accepted.
REQ-035 Reset mid-operation: rst pulsed 10 clk into busy -> ready=1, all vol=4'hF, all tone=0 the next cycle; a following data byte 0x3F updates tone0[9:4]=6'h3F.
